// File: rtl/parallel_in_serial_out_piso_pkg.sv
// Shared types and helpers for the PISO transmitter: FSM state encoding and
// the bit-counter width derived from the word width.
package piso_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_t;

  function automatic int piso_count_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/parallel_in_serial_out_piso_if.sv
// Load handshake, shift strobe and serial output bundle of the PISO transmitter.
// The master side offers words and strobes; the slave side is the transmitter.
interface parallel_in_serial_out_piso_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  Enable_In;
  logic                  Load_Valid_In;
  logic                  Load_Ready_Out;
  logic [DATA_WIDTH-1:0] Parallel_Data_In;
  logic                  Shift_Data_Signal_In;
  logic                  Serial_Data_Out;
  logic                  Serial_Valid_Out;
  logic                  Busy_Out;
  logic                  Done_Out;

  modport master (
    output Enable_In, Load_Valid_In, Parallel_Data_In, Shift_Data_Signal_In,
    input  Load_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Busy_Out, Done_Out
  );

  modport slave (
    input  Enable_In, Load_Valid_In, Parallel_Data_In, Shift_Data_Signal_In,
    output Load_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Busy_Out, Done_Out
  );
endinterface

// File: rtl/parallel_in_serial_out_piso_bit_counter.sv
// Down-counter tracking which bit of the word is on the line; load has
// priority over decrement and the zero flag marks the final bit.
module piso_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset_N,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Value,
  input  logic             i_Dec,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Zero
);
  logic [WIDTH-1:0] r_Bit_Count;

  always_ff @(posedge i_Clk or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_Bit_Count <= '0;
    end else if (i_Load) begin
      r_Bit_Count <= i_Load_Value;
    end else if (i_Dec) begin
      r_Bit_Count <= r_Bit_Count - WIDTH'(1);
    end
  end

  assign o_Count = r_Bit_Count;
  assign o_Zero  = (r_Bit_Count == '0);
endmodule

// File: rtl/parallel_in_serial_out_piso.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per shift strobe.
// Define PISO_LSB_FIRST_EN to transmit LSB first (default is MSB first).
module parallel_in_serial_out_piso
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input logic                     Clk_In,
  input logic                     Reset_N_In,
  parallel_in_serial_out_piso_if.slave bus
);
  localparam int CW = piso_count_width(DATA_WIDTH);

  piso_state_t           r_State;
  piso_state_t           w_Next_State;
  logic [DATA_WIDTH-1:0] r_Shift_Register;
  logic [DATA_WIDTH-1:0] w_Next_Shift_Register;
  logic                  r_Done;
  logic                  w_Next_Done;
  logic                  w_Load_Fire;
  logic                  w_Shift_Fire;
  logic                  w_Count_Load;
  logic                  w_Count_Dec;
  logic                  w_Count_Zero;
  logic [CW-1:0]         w_Count;
  logic                  w_Line_Bit;

  assign w_Load_Fire  = (r_State == PISO_IDLE)  && bus.Enable_In && bus.Load_Valid_In;
  assign w_Shift_Fire = (r_State == PISO_SHIFT) && bus.Enable_In && bus.Shift_Data_Signal_In;

  piso_bit_counter #(
    .WIDTH(CW)
  ) u_bit_counter (
    .i_Clk        (Clk_In),
    .i_Reset_N    (Reset_N_In),
    .i_Load       (w_Count_Load),
    .i_Load_Value (CW'(DATA_WIDTH - 1)),
    .i_Dec        (w_Count_Dec),
    .o_Count      (w_Count),
    .o_Zero       (w_Count_Zero)
  );

  always_comb begin
    w_Next_State          = r_State;
    w_Next_Shift_Register = r_Shift_Register;
    w_Next_Done           = 1'b0;
    w_Count_Load          = 1'b0;
    w_Count_Dec           = 1'b0;
    case (r_State)
      PISO_IDLE: begin
        if (w_Load_Fire) begin
          w_Next_State          = PISO_SHIFT;
          w_Next_Shift_Register = bus.Parallel_Data_In;
          w_Count_Load          = 1'b1;
        end
      end
      PISO_SHIFT: begin
        if (w_Shift_Fire) begin
          if (w_Count_Zero) begin
            // Last bit consumed: clearing here lets a new load land on the Done cycle.
            w_Next_State          = PISO_IDLE;
            w_Next_Shift_Register = '0;
            w_Next_Done           = 1'b1;
          end else begin
`ifdef PISO_LSB_FIRST_EN
            w_Next_Shift_Register = {1'b0, r_Shift_Register[DATA_WIDTH-1:1]};
`else
            w_Next_Shift_Register = {r_Shift_Register[DATA_WIDTH-2:0], 1'b0};
`endif
            w_Count_Dec           = 1'b1;
          end
        end
      end
      default: w_Next_State = PISO_IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      r_State          <= PISO_IDLE;
      r_Shift_Register <= '0;
      r_Done           <= 1'b0;
    end else begin
      r_State          <= w_Next_State;
      r_Shift_Register <= w_Next_Shift_Register;
      r_Done           <= w_Next_Done;
    end
  end

`ifdef PISO_LSB_FIRST_EN
  assign w_Line_Bit = r_Shift_Register[0];
`else
  assign w_Line_Bit = r_Shift_Register[DATA_WIDTH-1];
`endif

  // Outputs depend only on state and enable, never on the load request.
  assign bus.Load_Ready_Out   = (r_State == PISO_IDLE)  && bus.Enable_In;
  assign bus.Serial_Valid_Out = (r_State == PISO_SHIFT) && bus.Enable_In;
  assign bus.Serial_Data_Out  = (r_State == PISO_SHIFT) && bus.Enable_In && w_Line_Bit;
  assign bus.Busy_Out         = (r_State == PISO_SHIFT);
  assign bus.Done_Out         = r_Done;

  logic w_Unused;
  assign w_Unused = ^w_Count;
endmodule

// File: tb/tb_parallel_in_serial_out_piso.sv
// Directed bench for the PISO transmitter: a word-level model plus a SIPO
// receiver model are compared against the DUT on every falling edge.
module tb_parallel_in_serial_out_piso;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  parallel_in_serial_out_piso_if #(.DATA_WIDTH(W)) bus ();

  parallel_in_serial_out_piso #(.DATA_WIDTH(W)) u_dut (
    .Clk_In     (clk),
    .Reset_N_In (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: which word is in flight and how many bits have gone out.
  logic         m_busy;
  logic         m_done;
  int           m_idx;
  logic [W-1:0] m_word;
  logic [W-1:0] m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_idx  <= 0;
      m_word <= '0;
    end else begin
      m_done <= 1'b0;
      if (bus.Enable_In) begin
        if (!m_busy) begin
          if (bus.Load_Valid_In) begin
            m_busy <= 1'b1;
            m_word <= bus.Parallel_Data_In;
            m_idx  <= 0;
          end
        end else if (bus.Shift_Data_Signal_In) begin
          if (m_idx == W - 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_last <= m_word;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
      end
    end
  end

  function automatic logic exp_bit();
    if (!(m_busy && bus.Enable_In)) return 1'b0;
`ifdef PISO_LSB_FIRST_EN
    return m_word[m_idx];
`else
    return m_word[W-1-m_idx];
`endif
  endfunction

  logic [W-1:0] rx;

  always @(negedge clk) begin
    check("ready", 32'(bus.Load_Ready_Out), 32'(!m_busy && bus.Enable_In));
    check("svalid", 32'(bus.Serial_Valid_Out), 32'(m_busy && bus.Enable_In));
    check("sdata", 32'(bus.Serial_Data_Out), 32'(exp_bit()));
    check("busy", 32'(bus.Busy_Out), 32'(m_busy));
    check("done", 32'(bus.Done_Out), 32'(m_done));
    if (!rst_n) begin
      rx = '0;
    end else begin
      if (bus.Serial_Valid_Out && bus.Shift_Data_Signal_In) begin
`ifdef PISO_LSB_FIRST_EN
        rx = {bus.Serial_Data_Out, rx[W-1:1]};
`else
        rx = {rx[W-2:0], bus.Serial_Data_Out};
`endif
      end
      if (bus.Done_Out) check("sipo_word", 32'(rx), 32'(m_last));
    end
  end

  // Loads a word at the next edge, then strobes every 'period' cycles; optional
  // enable pause and a competing load attempt while the word is in flight.
  task automatic run_word(input logic [W-1:0] word, input int period,
                          input int pause_at, input int pause_len, input int interf_at,
                          input int exp_done, input int exp_busy, input string tag);
    logic [W-1:0] col;
    int nb;
    int busyc;
    int done_k;
    col = '0; nb = 0; busyc = 0; done_k = 0;
    bus.Load_Valid_In        = 1'b1;
    bus.Parallel_Data_In     = word;
    bus.Shift_Data_Signal_In = 1'b1;
    @(posedge clk); #1;
    bus.Load_Valid_In = 1'b0;
    for (int k = 1; k <= 400 && done_k == 0; k++) begin
      bus.Enable_In            = !(k > pause_at && k <= pause_at + pause_len);
      bus.Shift_Data_Signal_In = (k % period == 0);
      if (interf_at > 0 && k >= interf_at && k < interf_at + 3) begin
        bus.Load_Valid_In    = 1'b1;
        bus.Parallel_Data_In = 16'h1234;
      end else begin
        bus.Load_Valid_In = 1'b0;
      end
      @(negedge clk);
      if (!bus.Enable_In) begin
        check({tag, "_paused_data"}, 32'(bus.Serial_Data_Out), 32'd0);
        check({tag, "_paused_busy"}, 32'(bus.Busy_Out), 32'd1);
      end
      if (bus.Serial_Valid_Out && bus.Shift_Data_Signal_In) begin
`ifdef PISO_LSB_FIRST_EN
        col = {bus.Serial_Data_Out, col[W-1:1]};
`else
        col = {col[W-2:0], bus.Serial_Data_Out};
`endif
        nb++;
      end
      if (bus.Busy_Out) busyc++;
      if (bus.Done_Out) done_k = k;
      @(posedge clk); #1;
    end
    bus.Load_Valid_In        = 1'b0;
    bus.Shift_Data_Signal_In = 1'b0;
    bus.Enable_In            = 1'b1;
    check({tag, "_done_cycle"}, 32'(done_k), 32'(exp_done));
    check({tag, "_bits"}, 32'(col), 32'(word));
    check({tag, "_nbits"}, 32'(nb), 32'd16);
    check({tag, "_busy_cycles"}, 32'(busyc), 32'(exp_busy));
  endtask

  initial begin
    int saw_done;
    rst_n                    = 1'b0;
    bus.Enable_In            = 1'b1;
    bus.Load_Valid_In        = 1'b0;
    bus.Parallel_Data_In     = '0;
    bus.Shift_Data_Signal_In = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.Load_Ready_Out), 32'd1);
    check("rst_svalid", 32'(bus.Serial_Valid_Out), 32'd0);
    check("rst_busy", 32'(bus.Busy_Out), 32'd0);
    check("rst_done", 32'(bus.Done_Out), 32'd0);
    check("rst_sdata", 32'(bus.Serial_Data_Out), 32'd0);
    @(posedge clk); #1;

    run_word(16'hA5C3, 1, 0, 0, 0, 17, 16, "a5c3");
    run_word(16'h8001, 3, 0, 0, 0, 49, 48, "8001_slow");
    run_word(16'hFFFF, 1, 5, 10, 0, 27, 26, "ffff_pause");
    run_word(16'hC35A, 1, 0, 0, 8, 17, 16, "c35a_ignore");
    run_word(16'h0001, 1, 0, 0, 0, 17, 16, "w0001");

    // Abort a word mid-flight with reset.
    bus.Load_Valid_In        = 1'b1;
    bus.Parallel_Data_In     = 16'h5A5A;
    bus.Shift_Data_Signal_In = 1'b1;
    @(posedge clk); #1;
    bus.Load_Valid_In = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.Busy_Out), 32'd0);
    check("abort_svalid", 32'(bus.Serial_Valid_Out), 32'd0);
    check("abort_sdata", 32'(bus.Serial_Data_Out), 32'd0);
    check("abort_done", 32'(bus.Done_Out), 32'd0);
    check("abort_ready", 32'(bus.Load_Ready_Out), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Done_Out) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    @(posedge clk); #1;

    run_word(16'h1234, 1, 0, 0, 0, 17, 16, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/parallel_in_serial_out_piso.md
# parallel_in_serial_out_piso

Parameterised Parallel-In-Serial-Out (PISO) shift register: accepts a parallel word through a valid/ready load handshake and shifts it out one bit per shift strobe. It is the transmit-side counterpart of the 16-bit SIPO register. With a shared `Shift_Data_Signal_In` strobe, a SIPO receiver reassembles the word unchanged. Bits change on the rising edge so they are stable at the SIPO's falling-edge sample point.

## Interface
- `DATA_WIDTH`, default 16: word width; legal values are 2 or greater.
- `Clk_In`  input  1  system clock; all state updates on the rising edge.
- `Reset_N_In`  input  1  asynchronous, active-low reset.
- `Enable_In`  input  1  block enable; when low, state is frozen and outputs are gated.
- `Load_Valid_In`  input  1  parallel word is offered.
- `Load_Ready_Out`  output  1  block can accept a word.
- `Parallel_Data_In`  input  DATA_WIDTH  word to transmit.
- `Shift_Data_Signal_In`  input  1  shift strobe; advances one bit per rising edge while high.
- `Serial_Data_Out`  output  1  current serial bit.
- `Serial_Valid_Out`  output  1  `Serial_Data_Out` holds a valid bit of the current word.
- `Busy_Out`  output  1  word in flight.
- `Done_Out`  output  1  one-cycle pulse after the last bit is shifted.

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: word loaded; bit counter `r_Bit_Count` (width $clog2(DATA_WIDTH)) indexes the presented bit.
- IDLE:
  - `Load_Ready_Out = Enable_In`.
  - Load fires when `Enable_In && Load_Valid_In` at a rising edge. On load, `Parallel_Data_In` is captured into `r_Shift_Register`, `r_Bit_Count = DATA_WIDTH-1`, and the state goes to SHIFT.
- SHIFT:
  - `Load_Ready_Out = 0`, `Busy_Out = 1`, `Serial_Valid_Out = Enable_In`.
  - `Serial_Data_Out` = `r_Shift_Register[DATA_WIDTH-1]`, i.e. MSB first.
  - Rising edge with `Enable_In && Shift_Data_Signal_In`:
    - If `r_Bit_Count != 0`: shift the register left by 1 with 0 filled in, then decrement `r_Bit_Count`.
    - If `r_Bit_Count == 0`: go to IDLE, clear the register, and register `Done_Out = 1` for exactly one cycle.
  - Strobe low: hold the register, counter and output bit indefinitely. There is no timeout.
- A `Load_Valid_In` asserted while in SHIFT is ignored. It is not queued, and the word in flight is not corrupted.
- The earliest reload is in the same cycle `Done_Out` is high, because IDLE has been reached. Minimum word-to-word gap is 1 cycle.
- `Enable_In` low:
  - No state change.
  - `Serial_Data_Out = 0`, `Serial_Valid_Out = 0`, `Load_Ready_Out = 0`.
  - `Busy_Out` still reflects the state.
  - On re-enable, transmission resumes at the same bit.
- Reset (asynchronous, any time, including mid-word):
  - State goes to IDLE; register and counter are cleared.
  - `Serial_Data_Out = 0`, `Serial_Valid_Out = 0`, `Busy_Out = 0`, `Done_Out = 0`, `Load_Ready_Out = Enable_In`.
  - A partial word is discarded with no `Done_Out`.

## Timing
- Load-to-first-bit: 1 cycle. Bit N-1 (MSB) is on `Serial_Data_Out` in the cycle after the load edge.
- One bit per strobed cycle. With the strobe held high continuously, a word takes DATA_WIDTH cycles in SHIFT.
- `Done_Out` is high in the cycle after the last-bit strobe edge.
- The receiver samples on the falling edge mid-cycle, and `Serial_Data_Out` is stable across it.
- `Load_Ready_Out`, `Serial_Valid_Out` and `Serial_Data_Out` are combinational on state and `Enable_In` only. There is no combinational path from `Load_Valid_In`.

## Configuration
- Macro `PISO_LSB_FIRST_EN`.
- Defined: `Serial_Data_Out = r_Shift_Register[0]`, the register shifts right with 0 filled in, and the word is transmitted LSB first.
- Undefined (default): MSB first, left shift. This matches the SIPO receiver, which shifts in at bit 0.
- Counter, handshake and timing are identical in both builds.

## Structure
- Package `piso_pkg`:
  - state enum `piso_state_t` {PISO_IDLE, PISO_SHIFT}.
  - function `piso_count_width(width)` returning $clog2(width).
- Sub-module `piso_bit_counter`: down-counter with load, decrement and zero flag, parameterised by width. The top holds the shift register, FSM and output gating.

## Test plan
- Reset then release with `Enable_In` = 1 -> `Load_Ready_Out` = 1; `Serial_Valid_Out`, `Busy_Out` and `Done_Out` = 0; `Serial_Data_Out` = 0.
- Load 16'hA5C3 with the strobe held high -> over 16 cycles `Serial_Data_Out` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. `Done_Out` pulses on cycle 17. A SIPO model sharing the strobe reads 16'hA5C3.
- Load 16'h8001 and strobe every third cycle -> each bit is held 3 cycles; 48 cycles to `Done_Out`; serial output is 1, fourteen 0s, then 1.
- Mid-word (after 5 bits of 16'hFFFF): drop `Enable_In` for 10 cycles -> outputs are 0 and `Busy_Out` = 1. Re-enable -> the remaining 11 ones are sent, then `Done_Out`.
- After 7 bits: assert `Load_Valid_In` with 16'h1234 -> ignored and the original word completes. Then assert `Reset_N_In` low mid-word -> immediate IDLE and no `Done_Out`.
- With `PISO_LSB_FIRST_EN` defined: load 16'h0001 -> first bit 1, then fifteen 0s, then `Done_Out`.
